// File: rtl/ci_pkg.sv
// ci_pkg: shared definitions for the custom-instruction sequencer.
//   CI_W       : data width of the CI operand/result path (IEEE-754 single)
//   NAN_VAL    : quiet NaN recorded for a transaction abandoned by timeout
//   ci_state_e : sequencer FSM states (encoding visible on the debug port)
package ci_pkg;

  localparam int CI_W = 32;
  localparam logic [CI_W-1:0] NAN_VAL = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STORE  = 3'd3,
    ST_FINISH = 3'd4
  } ci_state_e;

endpackage

// File: rtl/ci_fifo.sv
// ci_fifo: synchronous show-ahead FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : advance enable; 0 freezes pointers and storage
//   clr         : empty the FIFO (wins over push/pop in the same cycle)
//   push/push_data : write request, ignored when full
//   pop         : read request, ignored when empty
//   head        : oldest entry, forced to 0 while empty
//   full/empty/count : occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable when
// the index bits match.
module ci_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = en && push && !full && !clr;
    do_pop   = en && pop && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (en && clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ci_sequencer.sv
// ci_sequencer: initiator side of the start/dataa -> done/result handshake.
// The host loads samples, pulses go, and the block issues each sample to the
// downstream unit in order, collecting results into a readable buffer.
//   clock, reset        : clock, asynchronous active-low reset
//   clk_en              : 0 freezes all state and holds all outputs
//   ld_valid/ld_data/ld_ready : sample load port
//   go                  : start sequencing all buffered samples (IDLE only)
//   busy, all_done, timeout_err : run status
//   ci_start/ci_dataa   : one-cycle start pulse and held operand
//   ci_done/ci_result   : downstream completion strobe and result
//   rd_en/rd_data/rd_valid : show-ahead result read port
//   dbg_state, dbg_sample_cnt, dbg_result_cnt : observability only
// Handshakes: a load transfers on a clock edge where clk_en & ld_valid &
// ld_ready; a read pops on an edge where clk_en & rd_en & rd_valid; ld_valid
// and rd_en may be held and do not depend on the ready/valid outputs.
module ci_sequencer
  import ci_pkg::*;
#(
  parameter int              DEPTH   = 16,
  parameter int              TIMEOUT = 255,
  parameter logic [CI_W-1:0] NAN_R   = NAN_VAL
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   ld_valid,
  input  logic [CI_W-1:0]        ld_data,
  output logic                   ld_ready,
  input  logic                   go,
  output logic                   busy,
  output logic                   all_done,
  output logic                   timeout_err,
  output logic                   ci_start,
  output logic [CI_W-1:0]        ci_dataa,
  input  logic                   ci_done,
  input  logic [CI_W-1:0]        ci_result,
  input  logic                   rd_en,
  output logic [CI_W-1:0]        rd_data,
  output logic                   rd_valid,
  output logic [2:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_sample_cnt,
  output logic [$clog2(DEPTH):0] dbg_result_cnt
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  ci_state_e         state_q, state_d;
  logic              ci_start_q, ci_start_d;
  logic [CI_W-1:0]   ci_dataa_q, ci_dataa_d;
  logic [CI_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              terr_q, terr_d;

  logic              ld_fire;
  logic              smp_pop, smp_full, smp_empty;
  logic [CI_W-1:0]   smp_head;
  logic              res_clr, res_push, res_full, res_empty;

  assign ld_ready    = (state_q == ST_IDLE) && !smp_full;
  assign ld_fire     = ld_valid && ld_ready;
  assign busy        = busy_q;
  assign all_done    = all_done_q;
  assign timeout_err = terr_q;
  assign ci_start    = ci_start_q;
  assign ci_dataa    = ci_dataa_q;
  assign rd_valid    = !res_empty;
  assign dbg_state   = state_q;

  ci_fifo #(.DATA_W(CI_W), .DEPTH(DEPTH)) u_sample_buf (
    .clk       (clock),
    .rst_n     (reset),
    .en        (clk_en),
    .clr       (1'b0),
    .push      (ld_fire),
    .push_data (ld_data),
    .pop       (smp_pop),
    .head      (smp_head),
    .full      (smp_full),
    .empty     (smp_empty),
    .count     (dbg_sample_cnt)
  );

  ci_fifo #(.DATA_W(CI_W), .DEPTH(DEPTH)) u_result_buf (
    .clk       (clock),
    .rst_n     (reset),
    .en        (clk_en),
    .clr       (res_clr),
    .push      (res_push),
    .push_data (cap_q),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (res_full),
    .empty     (res_empty),
    .count     (dbg_result_cnt)
  );

  always_comb begin
    state_d    = state_q;
    ci_start_d = 1'b0;
    ci_dataa_d = ci_dataa_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    all_done_d = 1'b0;
    terr_d     = terr_q;
    smp_pop    = 1'b0;
    res_clr    = 1'b0;
    res_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          res_clr = 1'b1;
          terr_d  = 1'b0;
          busy_d  = 1'b1;
          // A load in the same cycle as go lands first, so it counts.
          state_d = (smp_empty && !ld_fire) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        smp_pop    = 1'b1;
        ci_dataa_d = smp_head;
        ci_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (ci_done) begin
          cap_d   = ci_result;
          state_d = ST_STORE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          cap_d   = NAN_R;
          terr_d  = 1'b1;
          state_d = ST_STORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        // Result buffer is cleared at go and holds DEPTH entries, so the
        // full guard never blocks in practice.
        res_push = !res_full;
        state_d  = smp_empty ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        all_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ci_start_q <= 1'b0;
      ci_dataa_q <= '0;
      cap_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      terr_q     <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      ci_start_q <= ci_start_d;
      ci_dataa_q <= ci_dataa_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      terr_q     <= terr_d;
    end
  end

endmodule

// File: tb/tb_ci_sequencer.sv
module tb_ci_sequencer;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        go = 1'b0;
  logic        busy, all_done, timeout_err;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [2:0]  dbg_state;
  logic [4:0]  dbg_sample_cnt, dbg_result_cnt;

  always #5 clock = ~clock;

  ci_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .clk_en         (clk_en),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .go             (go),
    .busy           (busy),
    .all_done       (all_done),
    .timeout_err    (timeout_err),
    .ci_start       (ci_start),
    .ci_dataa       (ci_dataa),
    .ci_done        (ci_done),
    .ci_result      (ci_result),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .dbg_state      (dbg_state),
    .dbg_sample_cnt (dbg_sample_cnt),
    .dbg_result_cnt (dbg_result_cnt)
  );

  // ---------------- downstream unit model ----------------
  // Answers 2*x (exponent + 1 for the normal values used here) a fixed
  // number of advancing cycles after seeing ci_start; transaction skip_txn
  // is never answered.
  int          txn_id   = 0;
  int          skip_txn = -1;
  int          m_lat    = 4;
  int          m_cnt    = 0;
  bit          m_pend   = 1'b0;
  logic [31:0] m_data   = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ci_done   <= 1'b0;
      ci_result <= '0;
      m_pend    <= 1'b0;
      m_cnt     <= 0;
    end else if (clk_en) begin
      ci_done <= 1'b0;
      if (ci_start) begin
        txn_id <= txn_id + 1;
        m_pend <= (txn_id != skip_txn);
        m_cnt  <= m_lat;
        m_data <= ci_dataa;
      end else if (m_pend) begin
        if (m_cnt <= 1) begin
          ci_done   <= 1'b1;
          ci_result <= m_data + 32'h0080_0000;
          m_pend    <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int start_rise = 0, start_hi = 0, done_rise = 0;
  bit start_prev = 1'b0, done_prev = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (ci_start && !start_prev) start_rise++;
      if (ci_start && clk_en)      start_hi++;
      if (all_done && !done_prev)  done_rise++;
    end
    start_prev = ci_start;
    done_prev  = all_done;
  end

  // ---------------- scoreboard / checker ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] x, input string tag);
    check_eq(tag, 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_data  = x;
    tick(1);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_all_done(input int budget, input string tag);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      tick(1);
      n++;
      if (all_done) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      tick(1);
      n++;
      if (ci_start) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic read_results(input int n, input string tag);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check_eq(tag, rd_data, e);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
    end
    check_eq({tag, "_empty"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_all_done"}, 32'(all_done), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_eq({tag, "_ci_start"}, 32'(ci_start), 32'd0);
    check_eq({tag, "_ci_dataa"}, ci_dataa, 32'd0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_rd_data"}, rd_data, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int s0, h0, d0;
    logic [31:0] held;
    logic [31:0] x;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst");

    // Three samples, each answered as 2*x.
    s0 = start_rise; h0 = start_hi; d0 = done_rise;
    load(32'h4040_0000, "t1_ld0");
    load(32'h40A0_0000, "t1_ld1");
    load(32'h40E0_0000, "t1_ld2");
    pulse_go();
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_all_done(200, "t1_all_done");
    tick(2);
    check_eq("t1_starts", 32'(start_rise - s0), 32'd3);
    check_eq("t1_start_cycles", 32'(start_hi - h0), 32'd3);
    check_eq("t1_done_pulses", 32'(done_rise - d0), 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_terr", 32'(timeout_err), 32'd0);
    exp_q.push_back(32'h40C0_0000);
    exp_q.push_back(32'h4120_0000);
    exp_q.push_back(32'h4160_0000);
    read_results(3, "t1_rd");

    // Second of three is never answered -> NaN result, sticky error.
    skip_txn = txn_id + 1;
    load(32'h3F80_0000, "t3_ld0");
    load(32'h4000_0000, "t3_ld1");
    load(32'h4080_0000, "t3_ld2");
    pulse_go();
    wait_all_done(1000, "t3_all_done");
    tick(1);
    check_eq("t3_terr", 32'(timeout_err), 32'd1);
    exp_q.push_back(32'h4000_0000);
    exp_q.push_back(32'h7FC0_0000);
    exp_q.push_back(32'h4100_0000);
    read_results(3, "t3_rd");
    skip_txn = -1;

    // go with nothing buffered: one busy cycle, all_done two cycles after go.
    s0 = start_rise;
    pulse_go();
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_done_early", 32'(all_done), 32'd0);
    check_eq("t2_terr_cleared", 32'(timeout_err), 32'd0);
    tick(1);
    check_eq("t2_all_done", 32'(all_done), 32'd1);
    check_eq("t2_busy_off", 32'(busy), 32'd0);
    tick(1);
    check_eq("t2_done_once", 32'(all_done), 32'd0);
    check_eq("t2_no_start", 32'(start_rise - s0), 32'd0);

    // Sixteen samples fill the buffer; the seventeenth is refused.
    s0 = start_rise;
    for (int i = 0; i < 16; i++) begin
      x = 32'h3F80_0000 + (32'(i) << 23);
      load(x, "t4_ld");
      exp_q.push_back(x + 32'h0080_0000);
    end
    check_eq("t4_ld_ready_full", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1;
    ld_data  = 32'h4480_0000;
    tick(1);
    ld_valid = 1'b0;
    check_eq("t4_sample_cnt", 32'(dbg_sample_cnt), 32'd16);
    pulse_go();
    wait_all_done(400, "t4_all_done");
    check_eq("t4_starts", 32'(start_rise - s0), 32'd16);
    read_results(16, "t4_rd");

    // Freeze for five cycles while waiting on the first sample.
    s0 = start_rise; h0 = start_hi;
    load(32'h4100_0000, "t5_ld0");
    load(32'h4110_0000, "t5_ld1");
    pulse_go();
    wait_start(20, "t5_start_seen");
    held   = ci_dataa;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("t5_dataa_held", ci_dataa, held);
      check_eq("t5_state_wait", 32'(dbg_state), 32'd2);
    end
    clk_en = 1'b1;
    wait_all_done(200, "t5_all_done");
    check_eq("t5_dataa_first", held, 32'h4100_0000);
    check_eq("t5_starts", 32'(start_rise - s0), 32'd2);
    check_eq("t5_start_cycles", 32'(start_hi - h0), 32'd2);
    exp_q.push_back(32'h4180_0000);
    exp_q.push_back(32'h4190_0000);
    read_results(2, "t5_rd");

    // Reset while waiting on the second sample, then a clean run.
    load(32'h4040_0000, "t6_ld0");
    load(32'h40A0_0000, "t6_ld1");
    pulse_go();
    wait_start(20, "t6_start1");
    wait_start(40, "t6_start2");
    tick(1);
    check_eq("t6_in_wait", 32'(dbg_state), 32'd2);
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    tick(2);
    reset = 1'b1;
    tick(1);
    check_eq("t6_smp_empty", 32'(dbg_sample_cnt), 32'd0);
    load(32'h40E0_0000, "t6_ld2");
    pulse_go();
    wait_all_done(100, "t6_all_done");
    exp_q.push_back(32'h4160_0000);
    read_results(1, "t6_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
